// File: rtl/fpu_wb_ctl.sv
`default_nettype none
// ============================================================================
// Module : fpu_wb_ctl
// Brief  : FPU register-file writeback arbiter (FPU vs. load) with load queue
//          and per-register pending-write scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module fpu_wb_ctl #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fpu_valid,
  input  logic [4:0]                  fpu_rd,
  input  logic [XLEN-1:0]             fpu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [4:0]                  ld_rd,
  input  logic [XLEN-1:0]             ld_data,
  input  logic                        iss_valid,
  input  logic [4:0]                  iss_rd,
  output logic                        iss_rd_busy,
  input  logic [4:0]                  chk_raddr0,
  input  logic [4:0]                  chk_raddr1,
  output logic                        chk_busy0,
  output logic                        chk_busy1,
  output logic                        wen0,
  output logic [4:0]                  waddr0,
  output logic [XLEN-1:0]             wd0,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);

  localparam int c_PW = $clog2(LQ_DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(LQ_DEPTH);

  logic [31:1]     r_sb;
  logic [31:0]     w_sb_vec;
  logic [31:0]     w_sb_next;
  logic [4:0]      r_lq_rd   [LQ_DEPTH];
  logic [XLEN-1:0] r_lq_data [LQ_DEPTH];
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [c_CW-1:0] r_count;
  logic            r_wen;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_wd;

  logic            w_fpu_sel;
  logic            w_q_empty;
  logic            w_ld_acc;
  logic            w_ld_live;
  logic            w_deq;
  logic            w_byp;
  logic            w_enq;
  logic            w_wen;
  logic [4:0]      w_waddr;
  logic [XLEN-1:0] w_wd;

  // Register 0 is hard-wired not-busy through the zero LSB.
  assign w_sb_vec    = {r_sb, 1'b0};
  assign iss_rd_busy = w_sb_vec[iss_rd];
  assign chk_busy0   = w_sb_vec[chk_raddr0];
  assign chk_busy1   = w_sb_vec[chk_raddr1];

  assign ld_ready  = (r_count < c_FULL);
  assign w_q_empty = (r_count == '0);
  assign w_fpu_sel = fpu_valid && (fpu_rd != 5'd0);
  assign w_ld_acc  = ld_valid && ld_ready;
  assign w_ld_live = w_ld_acc && (ld_rd != 5'd0);
  assign w_deq     = !w_fpu_sel && !w_q_empty;
  assign w_byp     = !w_fpu_sel && w_q_empty && w_ld_live;
  assign w_enq     = w_ld_live && !w_byp;

  always_comb begin
    w_wen   = 1'b0;
    w_waddr = r_waddr;
    w_wd    = r_wd;
    if (w_fpu_sel) begin
      w_wen   = 1'b1;
      w_waddr = fpu_rd;
      w_wd    = fpu_data;
    end else if (w_deq) begin
      w_wen   = 1'b1;
      w_waddr = r_lq_rd[r_head];
      w_wd    = r_lq_data[r_head];
    end else if (w_byp) begin
      w_wen   = 1'b1;
      w_waddr = ld_rd;
      w_wd    = ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wd    <= '0;
    end else begin
      r_wen   <= w_wen;
      r_waddr <= w_waddr;
      r_wd    <= w_wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_deq) r_head <= r_head + c_PW'(1);
      if (w_enq) r_tail <= r_tail + c_PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_lq_rd[r_tail]   <= ld_rd;
      r_lq_data[r_tail] <= ld_data;
    end
  end

  // Clear applied before set so a same-edge re-issue keeps the bit busy.
  always_comb begin
    w_sb_next = w_sb_vec;
    if (r_wen) w_sb_next[r_waddr] = 1'b0;
    if (iss_valid) w_sb_next[iss_rd] = 1'b1;
    w_sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sb <= '0;
    else     r_sb <= w_sb_next[31:1];
  end

  assign wen0     = r_wen;
  assign waddr0   = r_waddr;
  assign wd0      = r_wd;
  assign lq_count = r_count;

  // Re-issuing a register whose write retires on this very edge is legal.
  ap_no_busy_issue: assert property (@(posedge clk) disable iff (rst)
    (iss_valid && iss_rd_busy) |-> (r_wen && (r_waddr == iss_rd)));

endmodule
`default_nettype wire

// File: tb/tb_fpu_wb_ctl.sv
`default_nettype none
// ============================================================================
// Module : tb_fpu_wb_ctl
// Brief  : Directed self-checking bench for fpu_wb_ctl.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fpu_wb_ctl;

  logic        clk;
  logic        rst;
  logic        fpu_valid;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_rd_busy;
  logic [4:0]  chk_raddr0;
  logic [4:0]  chk_raddr1;
  logic        chk_busy0;
  logic        chk_busy1;
  logic        wen0;
  logic [4:0]  waddr0;
  logic [31:0] wd0;
  logic [1:0]  lq_count;

  int n_checks = 0;
  int n_errors = 0;

  fpu_wb_ctl #(.XLEN(32), .LQ_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst),
    .fpu_valid(fpu_valid), .fpu_rd(fpu_rd), .fpu_data(fpu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rd_busy(iss_rd_busy),
    .chk_raddr0(chk_raddr0), .chk_raddr1(chk_raddr1),
    .chk_busy0(chk_busy0), .chk_busy1(chk_busy1),
    .wen0(wen0), .waddr0(waddr0), .wd0(wd0), .lq_count(lq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fpu_valid = 1'b0; fpu_rd = 5'd0; fpu_data = '0;
    ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = '0;
    iss_valid = 1'b0; iss_rd = 5'd0;
  endtask

  task automatic fpu(input logic [4:0] rd, input logic [31:0] d);
    fpu_valid = 1'b1; fpu_rd = rd; fpu_data = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [31:0] d);
    ld_valid = 1'b1; ld_rd = rd; ld_data = d;
  endtask

  task automatic expect_wb(input string tag, input logic en, input logic [4:0] a,
                           input logic [31:0] d);
    check({tag, ".wen0"}, 32'(wen0), 32'(en));
    if (en) begin
      check({tag, ".waddr0"}, 32'(waddr0), 32'(a));
      check({tag, ".wd0"}, wd0, d);
    end
  endtask

  initial begin
    idle();
    chk_raddr0 = 5'd0; chk_raddr1 = 5'd0;
    rst = 1'b1;
    #12;
    check("rst.wen0", 32'(wen0), 32'd0);
    check("rst.waddr0", 32'(waddr0), 32'd0);
    check("rst.wd0", wd0, 32'd0);
    check("rst.lq_count", 32'(lq_count), 32'd0);
    check("rst.ld_ready", 32'(ld_ready), 32'd1);
    chk_raddr0 = 5'd0; #1;
    check("rst.busy_r0", 32'(chk_busy0), 32'd0);
    rst = 1'b0;
    tick();

    // Issue r5, FPU writes it three cycles later.
    iss_valid = 1'b1; iss_rd = 5'd5; chk_raddr0 = 5'd5; #1;
    check("t2.iss_rd_busy_pre", 32'(iss_rd_busy), 32'd0);
    tick(); idle();
    for (int c = 1; c <= 3; c++) begin
      #1 check($sformatf("t2.busy_c%0d", c), 32'(chk_busy0), 32'd1);
      if (c == 3) fpu(5'd5, 32'h3F80);
      tick();
    end
    idle();
    expect_wb("t2.c4", 1'b1, 5'd5, 32'h3F80);
    check("t2.busy_c4", 32'(chk_busy0), 32'd1);
    tick();
    check("t2.busy_c5", 32'(chk_busy0), 32'd0);
    expect_wb("t2.c5", 1'b0, 5'd0, 32'd0);

    // FPU and load collide: FPU first, load from queue next.
    fpu(5'd3, 32'hA); ld(5'd4, 32'hB); #1;
    check("t3.ld_ready", 32'(ld_ready), 32'd1);
    tick(); idle();
    expect_wb("t3.c1", 1'b1, 5'd3, 32'hA);
    check("t3.cnt1", 32'(lq_count), 32'd1);
    tick();
    expect_wb("t3.c2", 1'b1, 5'd4, 32'hB);
    check("t3.cnt2", 32'(lq_count), 32'd0);
    tick();
    expect_wb("t3.c3", 1'b0, 5'd0, 32'd0);

    // FPU burst of 4 starves three offered loads.
    fpu(5'd10, 32'h110); ld(5'd1, 32'h201); #1;
    check("t4.c0.ready", 32'(ld_ready), 32'd1);
    tick();
    fpu(5'd11, 32'h111); ld(5'd2, 32'h202); #1;
    check("t4.c1.ready", 32'(ld_ready), 32'd1);
    check("t4.c1.cnt", 32'(lq_count), 32'd1);
    expect_wb("t4.c1", 1'b1, 5'd10, 32'h110);
    tick();
    fpu(5'd12, 32'h112); ld(5'd3, 32'h203); #1;
    check("t4.c2.ready", 32'(ld_ready), 32'd0);
    check("t4.c2.cnt", 32'(lq_count), 32'd2);
    expect_wb("t4.c2", 1'b1, 5'd11, 32'h111);
    tick();
    fpu(5'd13, 32'h113); #1;
    check("t4.c3.ready", 32'(ld_ready), 32'd0);
    expect_wb("t4.c3", 1'b1, 5'd12, 32'h112);
    tick();
    fpu_valid = 1'b0; fpu_rd = 5'd0; #1;
    check("t4.c4.ready", 32'(ld_ready), 32'd0);
    check("t4.c4.cnt", 32'(lq_count), 32'd2);
    expect_wb("t4.c4", 1'b1, 5'd13, 32'h113);
    tick();
    check("t4.c5.ready", 32'(ld_ready), 32'd1);
    check("t4.c5.cnt", 32'(lq_count), 32'd1);
    expect_wb("t4.c5", 1'b1, 5'd1, 32'h201);
    tick(); idle();
    check("t4.c6.cnt", 32'(lq_count), 32'd1);
    expect_wb("t4.c6", 1'b1, 5'd2, 32'h202);
    tick();
    check("t4.c7.cnt", 32'(lq_count), 32'd0);
    expect_wb("t4.c7", 1'b1, 5'd3, 32'h203);
    tick();
    expect_wb("t4.c8", 1'b0, 5'd0, 32'd0);

    // Re-issue r7 on the edge its write retires: bit must stay set.
    iss_valid = 1'b1; iss_rd = 5'd7; chk_raddr0 = 5'd7; chk_raddr1 = 5'd7;
    tick(); idle();
    fpu(5'd7, 32'h77); #1;
    check("t5.busy_pre", 32'(chk_busy0), 32'd1);
    tick(); idle();
    expect_wb("t5.wb", 1'b1, 5'd7, 32'h77);
    iss_valid = 1'b1; iss_rd = 5'd7; #1;
    check("t5.iss_rd_busy", 32'(iss_rd_busy), 32'd1);
    tick(); idle(); #1;
    check("t5.busy0_after", 32'(chk_busy0), 32'd1);
    check("t5.busy1_after", 32'(chk_busy1), 32'd1);
    fpu(5'd7, 32'h78);
    tick(); idle();
    tick();
    check("t5.busy_clear", 32'(chk_busy0), 32'd0);

    // rd=0 results are dropped; load still handshakes.
    fpu(5'd0, 32'hDEAD); ld(5'd0, 32'hBEEF); #1;
    check("t6.ld_ready", 32'(ld_ready), 32'd1);
    tick(); idle();
    expect_wb("t6.c1", 1'b0, 5'd0, 32'd0);
    check("t6.cnt", 32'(lq_count), 32'd0);
    ld(5'd0, 32'hBEEF);
    tick(); idle();
    expect_wb("t6.c2", 1'b0, 5'd0, 32'd0);
    check("t6.cnt2", 32'(lq_count), 32'd0);

    // Async reset mid-stream with two queued loads.
    iss_valid = 1'b1; iss_rd = 5'd21; chk_raddr0 = 5'd21; chk_raddr1 = 5'd23;
    tick(); idle();
    fpu(5'd20, 32'h120); ld(5'd21, 32'h221);
    tick();
    fpu(5'd22, 32'h122); ld(5'd23, 32'h223);
    tick(); idle(); #1;
    check("t1.pre.cnt", 32'(lq_count), 32'd2);
    expect_wb("t1.pre", 1'b1, 5'd22, 32'h122);
    check("t1.pre.busy", 32'(chk_busy0), 32'd1);
    rst = 1'b1; #1;
    check("t1.rst.wen0", 32'(wen0), 32'd0);
    check("t1.rst.cnt", 32'(lq_count), 32'd0);
    check("t1.rst.ready", 32'(ld_ready), 32'd1);
    check("t1.rst.busy0", 32'(chk_busy0), 32'd0);
    check("t1.rst.busy1", 32'(chk_busy1), 32'd0);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("t1.post%0d.wen0", c), 32'(wen0), 32'd0);
      check($sformatf("t1.post%0d.cnt", c), 32'(lq_count), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
